// File: rtl/rf_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_arb_pkg
// Description : Shared constants and types for the register-file write
//               arbiter (widths, zero register, requester id, write entry).
// Revision    : 1.0 - initial release
// ============================================================================
package rf_arb_pkg;

  localparam int REG_W  = 4;
  localparam int DATA_W = 16;

  // Writes to this register are architecturally discarded.
  localparam int unsigned ZERO_REG = 0;

  typedef enum logic [0:0] {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  typedef struct packed {
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

endpackage : rf_arb_pkg
`default_nettype wire

// File: rtl/rf_wr_slot.sv
`default_nettype none
// ============================================================================
// Module      : rf_wr_slot
// Description : One-entry write holding slot. A load and a grant in the same
//               cycle keeps the slot full with the new entry.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wr_slot
  import rf_arb_pkg::*;
#(
  parameter int REG_W  = rf_arb_pkg::REG_W,
  parameter int DATA_W = rf_arb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [REG_W-1:0]  i_reg,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_full,
  output logic [REG_W-1:0]  o_reg,
  output logic [DATA_W-1:0] o_data
);

  logic              r_full;
  logic [REG_W-1:0]  r_reg;
  logic [DATA_W-1:0] r_data;

  // Load has priority over the grant-clear so refill-on-grant keeps the slot full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 1'b0;
      r_reg  <= '0;
      r_data <= '0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_reg  <= i_reg;
      r_data <= i_data;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_reg  = r_reg;
  assign o_data = r_data;

endmodule : rf_wr_slot
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter
// Description : Shares the register file write port between the WB stage (A)
//               and a multi-cycle source (B). Each requester has a one-entry
//               slot; one slot per cycle is granted into a registered write
//               stage. Exports a per-register busy mask for hazard checks.
//               Optional macro RF_ARB_STARVE_GUARD_EN adds a starvation
//               counter that forces a B grant after STARVE_LIMIT denials.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DATA_W       = rf_arb_pkg::DATA_W,
  parameter int REG_W        = rf_arb_pkg::REG_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [REG_W-1:0]    a_reg,
  input  logic [DATA_W-1:0]   a_data,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [REG_W-1:0]    b_reg,
  input  logic [DATA_W-1:0]   b_data,
  output logic                WriteReg,
  output logic [REG_W-1:0]    DstReg,
  output logic [DATA_W-1:0]   DstData,
  output logic [2**REG_W-1:0] busy_mask
);

  localparam logic [REG_W-1:0] c_zeroReg = REG_W'(ZERO_REG);

  logic              w_aFull, w_bFull;
  logic [REG_W-1:0]  w_aReg, w_bReg;
  logic [DATA_W-1:0] w_aData, w_bData;
  logic              w_aLoad, w_bLoad;
  logic              w_grantA, w_grantB, w_grantValid;
  req_id_t           w_grantId;
  logic [REG_W-1:0]  w_grantReg;
  logic [DATA_W-1:0] w_grantData;
  logic              w_bStarved;
  logic              r_bOlder;
  logic              r_writeReg;
  logic [REG_W-1:0]  r_dstReg;
  logic [DATA_W-1:0] r_dstData;
  logic [2**REG_W-1:0] w_busyMask;

  assign a_ready = !w_aFull || w_grantA;
  assign b_ready = !w_bFull || w_grantB;
  assign w_aLoad = a_valid && a_ready;
  assign w_bLoad = b_valid && b_ready;

  rf_wr_slot #(.REG_W(REG_W), .DATA_W(DATA_W)) u_slotA (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_aLoad),
    .i_clear (w_grantA),
    .i_reg   (a_reg),
    .i_data  (a_data),
    .o_full  (w_aFull),
    .o_reg   (w_aReg),
    .o_data  (w_aData)
  );

  rf_wr_slot #(.REG_W(REG_W), .DATA_W(DATA_W)) u_slotB (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_bLoad),
    .i_clear (w_grantB),
    .i_reg   (b_reg),
    .i_data  (b_data),
    .o_full  (w_bFull),
    .o_reg   (w_bReg),
    .o_data  (w_bData)
  );

`ifdef RF_ARB_STARVE_GUARD_EN
  localparam int c_cntW = $clog2(STARVE_LIMIT + 1);
  logic [c_cntW-1:0] r_starveCnt;

  // Count cycles B waits while full; saturate at the limit, clear on a B grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starveCnt <= '0;
    end else if (w_grantB) begin
      r_starveCnt <= '0;
    end else if (w_bFull && (r_starveCnt != c_cntW'(STARVE_LIMIT))) begin
      r_starveCnt <= r_starveCnt + c_cntW'(1);
    end
  end

  assign w_bStarved = (r_starveCnt == c_cntW'(STARVE_LIMIT));
`else
  // Without the guard B is never forced ahead of A (constant false).
  assign w_bStarved = (STARVE_LIMIT < 0);
`endif

  // Pick one full slot: same register goes to the older entry, else A unless B is starved.
  always_comb begin
    w_grantValid = w_aFull || w_bFull;
    w_grantId    = REQ_A;
    if (w_aFull && w_bFull) begin
      if (w_aReg == w_bReg) begin
        w_grantId = r_bOlder ? REQ_B : REQ_A;
      end else if (w_bStarved) begin
        w_grantId = REQ_B;
      end
    end else if (w_bFull) begin
      w_grantId = REQ_B;
    end
  end

  assign w_grantA    = w_grantValid && (w_grantId == REQ_A);
  assign w_grantB    = w_grantValid && (w_grantId == REQ_B);
  assign w_grantReg  = (w_grantId == REQ_B) ? w_bReg  : w_aReg;
  assign w_grantData = (w_grantId == REQ_B) ? w_bData : w_aData;

  // Track which slot holds the older entry; a fill beside a waiting entry is younger.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bOlder <= 1'b0;
    end else if (w_aLoad && w_bLoad) begin
      r_bOlder <= 1'b0;
    end else if (w_aLoad && w_bFull && !w_grantB) begin
      r_bOlder <= 1'b1;
    end else if (w_bLoad && w_aFull && !w_grantA) begin
      r_bOlder <= 1'b0;
    end
  end

  // Register the granted entry; writes to the zero register never raise WriteReg.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_writeReg <= 1'b0;
      r_dstReg   <= '0;
      r_dstData  <= '0;
    end else if (w_grantValid) begin
      r_writeReg <= (w_grantReg != c_zeroReg);
      r_dstReg   <= w_grantReg;
      r_dstData  <= w_grantData;
    end else begin
      r_writeReg <= 1'b0;
    end
  end

  // Busy bits for every register with a write in a slot or in the write stage.
  always_comb begin
    w_busyMask = '0;
    if (w_aFull && (w_aReg != c_zeroReg)) w_busyMask[w_aReg] = 1'b1;
    if (w_bFull && (w_bReg != c_zeroReg)) w_busyMask[w_bReg] = 1'b1;
    if (r_writeReg) w_busyMask[r_dstReg] = 1'b1;
  end

  assign WriteReg  = r_writeReg;
  assign DstReg    = r_dstReg;
  assign DstData   = r_dstData;
  assign busy_mask = w_busyMask;

endmodule : rf_write_arbiter
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Directed self-checking bench for rf_write_arbiter. Covers
//               RF_ARB_STARVE_GUARD_EN in both builds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              a_valid, b_valid;
  logic              a_ready, b_ready;
  logic [REG_W-1:0]  a_reg, b_reg;
  logic [DATA_W-1:0] a_data, b_data;
  logic              WriteReg;
  logic [REG_W-1:0]  DstReg;
  logic [DATA_W-1:0] DstData;
  logic [2**REG_W-1:0] busy_mask;

  int nChecks = 0;
  int nErrors = 0;

  rf_write_arbiter #(.DATA_W(DATA_W), .REG_W(REG_W), .STARVE_LIMIT(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_reg     (a_reg),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_reg     (b_reg),
    .b_data    (b_data),
    .WriteReg  (WriteReg),
    .DstReg    (DstReg),
    .DstData   (DstData),
    .busy_mask (busy_mask)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic stepNeg();
    @(negedge clk);
  endtask

  int found;
  int seenWrite;

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    a_reg = '0; b_reg = '0; a_data = '0; b_data = '0;

    // Reset state
    stepNeg();
    checkVal("rst_wr",    WriteReg,  0);
    checkVal("rst_dst",   DstReg,    0);
    checkVal("rst_data",  DstData,   0);
    checkVal("rst_busy",  busy_mask, 0);
    checkVal("rst_ardy",  a_ready,   1);
    checkVal("rst_brdy",  b_ready,   1);
    rst = 1'b0;
    stepNeg();

    // Single A write: reg 3, BEEF
    a_valid = 1'b1; a_reg = 4'd3; a_data = 16'hBEEF;
    checkVal("t1_ardy", a_ready, 1);
    stepNeg();
    a_valid = 1'b0;
    checkVal("t1_wr0",   WriteReg,  0);
    checkVal("t1_busy0", busy_mask, 16'h0008);
    stepNeg();
    checkVal("t1_wr1",   WriteReg,  1);
    checkVal("t1_dst",   DstReg,    3);
    checkVal("t1_data",  DstData,   16'hBEEF);
    checkVal("t1_busy1", busy_mask, 16'h0008);
    stepNeg();
    checkVal("t1_wr2",   WriteReg,  0);
    checkVal("t1_busy2", busy_mask, 0);
    checkVal("t1_hold",  DstReg,    3);

    // Contention, different regs: A(2,1111) and B(5,2222) at the same edge
    a_valid = 1'b1; a_reg = 4'd2; a_data = 16'h1111;
    b_valid = 1'b1; b_reg = 4'd5; b_data = 16'h2222;
    stepNeg();
    a_valid = 1'b0; b_valid = 1'b0;
    checkVal("t2_brdy0", b_ready,   0);
    checkVal("t2_busy0", busy_mask, 16'h0024);
    stepNeg();
    checkVal("t2_wrA",   WriteReg,  1);
    checkVal("t2_dstA",  DstReg,    2);
    checkVal("t2_datA",  DstData,   16'h1111);
    checkVal("t2_busy1", busy_mask, 16'h0024);
    stepNeg();
    checkVal("t2_wrB",   WriteReg,  1);
    checkVal("t2_dstB",  DstReg,    5);
    checkVal("t2_datB",  DstData,   16'h2222);
    checkVal("t2_busy2", busy_mask, 16'h0020);
    stepNeg();
    checkVal("t2_idle",  WriteReg,  0);
    checkVal("t2_busy3", busy_mask, 0);

    // Same-reg ordering: B(7,AAAA) waits behind A(4,0404); A(7,5555) follows one cycle later
    a_valid = 1'b1; a_reg = 4'd4; a_data = 16'h0404;
    b_valid = 1'b1; b_reg = 4'd7; b_data = 16'hAAAA;
    stepNeg();
    b_valid = 1'b0;
    a_reg = 4'd7; a_data = 16'h5555;
    checkVal("t3_ardy0", a_ready,   1);
    checkVal("t3_brdy0", b_ready,   0);
    checkVal("t3_busy0", busy_mask, 16'h0090);
    stepNeg();
    a_valid = 1'b0;
    checkVal("t3_dst4",  DstReg,    4);
    checkVal("t3_dat4",  DstData,   16'h0404);
    checkVal("t3_ardy1", a_ready,   0);
    checkVal("t3_brdy1", b_ready,   1);
    checkVal("t3_busy1", busy_mask, 16'h0090);
    stepNeg();
    checkVal("t3_wrB",   WriteReg,  1);
    checkVal("t3_dstB",  DstReg,    7);
    checkVal("t3_datB",  DstData,   16'hAAAA);
    stepNeg();
    checkVal("t3_wrA",   WriteReg,  1);
    checkVal("t3_dstA",  DstReg,    7);
    checkVal("t3_datA",  DstData,   16'h5555);
    stepNeg();
    checkVal("t3_idle",  WriteReg,  0);

    // Register 0 write: accepted, but no WriteReg and no busy bit
    a_valid = 1'b1; a_reg = 4'd0; a_data = 16'hFFFF;
    checkVal("t4_ardy", a_ready, 1);
    stepNeg();
    a_valid = 1'b0;
    checkVal("t4_busy0", busy_mask, 0);
    checkVal("t4_wr0",   WriteReg,  0);
    stepNeg();
    checkVal("t4_wr1",   WriteReg,  0);
    checkVal("t4_dst",   DstReg,    0);
    checkVal("t4_data",  DstData,   16'hFFFF);
    checkVal("t4_busy1", busy_mask, 0);
    stepNeg();
    checkVal("t4_ardy1", a_ready,   1);

    // Starvation: A streams to reg 1, B holds one write to reg 9
    a_valid = 1'b1; a_reg = 4'd1; a_data = 16'h0001;
    b_valid = 1'b1; b_reg = 4'd9; b_data = 16'h9999;
    found = 0;
    for (int i = 1; i <= 12; i++) begin
      stepNeg();
      if (i == 1) b_valid = 1'b0;
      if (i == 3) checkVal("t5_brdy", b_ready, 0);
      a_data = a_data + 16'h0001;
      if (found == 0 && WriteReg && DstReg == 4'd9) found = i;
    end
`ifdef RF_ARB_STARVE_GUARD_EN
    checkVal("t5_forced", found, 6);
`else
    checkVal("t5_starved", found, 0);
`endif
    a_valid = 1'b0;
    for (int i = 0; i < 4; i++) stepNeg();
    checkVal("t5_drain", busy_mask, 0);

    // Reset mid-operation with both slots full
    a_valid = 1'b1; a_reg = 4'd3; a_data = 16'h3333;
    b_valid = 1'b1; b_reg = 4'd6; b_data = 16'h6666;
    stepNeg();
    a_valid = 1'b0; b_valid = 1'b0;
    checkVal("t6_busyPre", busy_mask, 16'h0048);
    #2 rst = 1'b1;
    #1;
    checkVal("t6_wr",   WriteReg,  0);
    checkVal("t6_dst",  DstReg,    0);
    checkVal("t6_data", DstData,   0);
    checkVal("t6_busy", busy_mask, 0);
    stepNeg();
    rst = 1'b0;
    checkVal("t6_ardy", a_ready, 1);
    checkVal("t6_brdy", b_ready, 1);
    seenWrite = 0;
    for (int i = 0; i < 4; i++) begin
      stepNeg();
      if (WriteReg) seenWrite++;
    end
    checkVal("t6_stale", seenWrite, 0);
    checkVal("t6_busyPost", busy_mask, 0);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_rf_write_arbiter
`default_nettype wire
